// File: rtl/hazard_scoreboard_if.sv
// Decode/execute/control-side signal bundle for the hazard scoreboard.
// The master drives the pipeline state. The slave is the scoreboard itself.
interface hazard_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int NSTAGE = 3,
    parameter int CNT_W  = 16
);
    logic                     flush;
    logic                     id_valid;
    logic [REG_W-1:0]         id_rs;
    logic [REG_W-1:0]         id_rt;
    logic                     id_is_jb;
    logic                     id_is_md;
    logic                     id_rd_hilo;
    logic [REG_W-1:0]         ex_rs;
    logic [REG_W-1:0]         ex_rt;
    logic [NSTAGE*REG_W-1:0]  stg_regf;
    logic [NSTAGE*DATA_W-1:0] stg_data;
    logic [NSTAGE-1:0]        stg_ready;

    logic                     fwd_id_rs;
    logic                     fwd_id_rt;
    logic [DATA_W-1:0]        fwd_id_rs_data;
    logic [DATA_W-1:0]        fwd_id_rt_data;
    logic                     fwd_ex_rs;
    logic                     fwd_ex_rt;
    logic [DATA_W-1:0]        fwd_ex_rs_data;
    logic [DATA_W-1:0]        fwd_ex_rt_data;
    logic                     stall;
    logic                     md_busy;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output flush, id_valid, id_rs, id_rt, id_is_jb, id_is_md, id_rd_hilo,
               ex_rs, ex_rt, stg_regf, stg_data, stg_ready,
        input  fwd_id_rs, fwd_id_rt, fwd_id_rs_data, fwd_id_rt_data,
               fwd_ex_rs, fwd_ex_rt, fwd_ex_rs_data, fwd_ex_rt_data,
               stall, md_busy, stall_cnt
    );

    modport slave (
        input  flush, id_valid, id_rs, id_rt, id_is_jb, id_is_md, id_rd_hilo,
               ex_rs, ex_rt, stg_regf, stg_data, stg_ready,
        output fwd_id_rs, fwd_id_rt, fwd_id_rs_data, fwd_id_rt_data,
               fwd_ex_rs, fwd_ex_rt, fwd_ex_rs_data, fwd_ex_rt_data,
               stall, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Forwarding and interlock unit: youngest-match operand forwarding over NSTAGE
// producer stages, mul/div occupancy scoreboard and a saturating stall counter.
module hazard_scoreboard #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int NSTAGE = 3,
    parameter int JB_MIN = 2,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int MD_W = $clog2(MD_LAT + 1);

    typedef struct packed {
        logic              hit;
        logic              rdy;
        logic              early;
        logic [DATA_W-1:0] data;
    } pick_t;

    // Scanning from the oldest stage down lets the youngest match overwrite.
    function automatic pick_t pick_stage(
        input logic [REG_W-1:0]         r,
        input int                       lo,
        input logic [NSTAGE*REG_W-1:0]  regf,
        input logic [NSTAGE*DATA_W-1:0] data,
        input logic [NSTAGE-1:0]        ready
    );
        pick_t p;
        p = '0;
        for (int k = NSTAGE - 1; k >= lo; k--) begin
            if (regf[k*REG_W +: REG_W] != '0 && regf[k*REG_W +: REG_W] == r) begin
                p.hit   = 1'b1;
                p.rdy   = ready[k];
                p.early = (k < JB_MIN);
                p.data  = data[k*DATA_W +: DATA_W];
            end
        end
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic blocks(input pick_t p, input logic is_jb);
        return p.hit && (!p.rdy || (is_jb && p.early));
    endfunction

    pick_t            id_rs_pick, id_rt_pick, ex_rs_pick, ex_rt_pick;
    logic [MD_W-1:0]  md_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             md_busy;
    logic             data_stall;
    logic             hilo_stall;
    logic             stall;
    logic             md_issue;

    always_comb begin
        id_rs_pick = pick_stage(bus.id_rs, 0, bus.stg_regf, bus.stg_data, bus.stg_ready);
        id_rt_pick = pick_stage(bus.id_rt, 0, bus.stg_regf, bus.stg_data, bus.stg_ready);
        ex_rs_pick = pick_stage(bus.ex_rs, 1, bus.stg_regf, bus.stg_data, bus.stg_ready);
        ex_rt_pick = pick_stage(bus.ex_rt, 1, bus.stg_regf, bus.stg_data, bus.stg_ready);
    end

    assign md_busy    = (md_cnt != '0);
    assign data_stall = bus.id_valid &&
                        (blocks(id_rs_pick, bus.id_is_jb) || blocks(id_rt_pick, bus.id_is_jb));
    assign hilo_stall = bus.id_valid && (bus.id_rd_hilo || bus.id_is_md) && md_busy;
    // A flush discards whatever sits in ID, so it never needs to be held.
    assign stall      = (data_stall || hilo_stall) && !bus.flush;
    assign md_issue   = bus.id_valid && bus.id_is_md && !stall && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (bus.flush) begin
            md_cnt <= '0;
        end else if (md_issue) begin
            md_cnt <= MD_W'(MD_LAT);
        end else if (md_busy) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign bus.fwd_id_rs      = id_rs_pick.hit;
    assign bus.fwd_id_rt      = id_rt_pick.hit;
    assign bus.fwd_id_rs_data = id_rs_pick.data;
    assign bus.fwd_id_rt_data = id_rt_pick.data;
    assign bus.fwd_ex_rs      = ex_rs_pick.hit;
    assign bus.fwd_ex_rt      = ex_rt_pick.hit;
    assign bus.fwd_ex_rs_data = ex_rs_pick.data;
    assign bus.fwd_ex_rt_data = ex_rt_pick.data;
    assign bus.stall          = stall;
    assign bus.md_busy        = md_busy;
    assign bus.stall_cnt      = stall_cnt;
endmodule
